pulse_kernel_rom: RTL and testbench
===================================

# pulse_kernel_rom

Support block for the camera-pipeline control path. It converts two asynchronous push-button levels into single-cycle, clock-synchronous pulses that step brightness up and down. It also provides two read-only Gaussian convolution kernels for the blur stages: 11x11 and 5x5, both binomial and both with a registered read. It sits between the board I/O (KEY inputs) and the control logic that generates the per-stage enable signals.

## Interface
Parameters:
- KEY_ACTIVE_LOW, 1, button level polarity; 1 means a pressed button reads 0 (DE1-SoC KEY).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- key_inc  in  1  raw button level for increment; asynchronous.
- key_dec  in  1  raw button level for decrement; asynchronous.
- inc_pulse  out  1  one-cycle pulse per key_inc press.
- dec_pulse  out  1  one-cycle pulse per key_dec press.
- rd_en11  in  1  read enable, 11x11 ROM.
- addr11  in  7  11x11 index, row*11+col, valid range 0..120.
- data11  out  16  11x11 coefficient.
- rd_en5  in  1  read enable, 5x5 ROM.
- addr5  in  5  5x5 index, row*5+col, valid range 0..24.
- data5  out  8  5x5 coefficient.

## Operation
- Level-to-pulse (one identical channel per key):
  - The raw level is XORed with polarity to give act = 1 while pressed.
  - act passes through two flops (s1, s2); s2 is delayed into a third flop, prev.
  - pulse = s2 & ~prev, so it is high for exactly one cycle per released-to-pressed transition.
  - No pulse is generated on release.
  - A held button produces exactly one pulse.
  - No debounce filtering: each clean transition seen at s2 produces one pulse.
- The two channels are fully independent; simultaneous presses give simultaneous pulses.
- 11x11 ROM contents: entry(r,c) = b[r]*b[c], with b = 1,10,45,120,210,252,210,120,45,10,1.
  - Maximum is 63504 at index 60; the kernel sums to 2^20.
- 5x5 ROM contents: entry(r,c) = g[r]*g[c], with g = 1,4,6,4,1.
  - Maximum is 36 at index 12; the kernel sums to 256.
- ROM read rules (both ROMs):
  - Output register loads the addressed entry when rd_en=1.
  - Output register holds its value when rd_en=0.
  - An out-of-range address (addr11 ≥ 121, addr5 ≥ 25) reads 0.
- Contents are constant; there is no write port.

## Timing
- Reset, checked at a clock edge with rst=1:
  - s1, s2 and prev are cleared to 0 (inactive).
  - inc_pulse and dec_pulse are 0.
  - data11 and data5 are 0.
- Pulse latency:
  - The press becomes stable before clock edge k and is captured in s1 at k.
  - s2 is set at k+1.
  - pulse is high from k+1 to k+2, exactly one cycle.
  - prev catches up at k+2.
- Button held through reset: after rst falls, act propagates again and one pulse occurs 2 edges after the first non-reset edge.
- Reset asserted while a pulse is high: the pulse drops at that edge.
- A press shorter than one clock may be missed; that is acceptable.
- ROM read latency is 1 cycle: addr and rd_en sampled at edge k give data valid after k until the next load.
- rst has priority over rd_en.

## Test plan
- Reset, then hold key_inc=0 (pressed, active-low) for 10 cycles -> inc_pulse=1 for exactly one cycle, 2 edges after the press edge; dec_pulse stays 0.
- Release key_inc, then press key_inc and key_dec on the same cycle -> inc_pulse and dec_pulse both pulse once, on the same cycle; no pulse on release.
- Assert rst while key_dec is held, then deassert -> outputs 0 during reset; one dec_pulse 2 edges after reset ends.
- rd_en11=1, addr11 = 0, 1, 60, 120, then 121 -> data11 = 1, 10, 63504, 1, then 0, each 1 cycle after its address.
- rd_en5=1, addr5 = 12, 7, 0, then 30 -> data5 = 36, 24, 1, then 0.
- Set rd_en5=0 and change addr5 -> data5 holds its last value.
- Sweep all 121 and all 25 entries -> sums are 1048576 and 256.

Source files
------------

// File: rtl/pulse_kernel_rom.sv
// pulse_kernel_rom
// Turns two asynchronous push-button levels into single-cycle pulses for
// brightness up/down, and serves two constant binomial (Gaussian) blur
// kernels, 11x11 and 5x5, through registered read ports.

module pulse_kernel_rom #(
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_inc,
  input  logic        i_key_dec,
  output logic        o_inc_pulse,
  output logic        o_dec_pulse,
  input  logic        i_rd_en11,
  input  logic [6:0]  i_addr11,
  output logic [15:0] o_data11,
  input  logic        i_rd_en5,
  input  logic [4:0]  i_addr5,
  output logic [7:0]  o_data5
);

  // Row 10 of Pascal's triangle: one axis of the 11x11 kernel.
  function automatic int binom11(input int k);
    case (k)
      0, 10:   binom11 = 1;
      1, 9:    binom11 = 10;
      2, 8:    binom11 = 45;
      3, 7:    binom11 = 120;
      4, 6:    binom11 = 210;
      5:       binom11 = 252;
      default: binom11 = 0;
    endcase
  endfunction

  // Row 4 of Pascal's triangle: one axis of the 5x5 kernel.
  function automatic int gauss5(input int k);
    case (k)
      0, 4:    gauss5 = 1;
      1, 3:    gauss5 = 4;
      2:       gauss5 = 6;
      default: gauss5 = 0;
    endcase
  endfunction

  logic w_inc_act;
  logic w_dec_act;
  logic r_inc_s1, r_inc_s2, r_inc_prev;
  logic r_dec_s1, r_dec_s2, r_dec_prev;

  // Polarity is folded in before synchronisation so every flop holds "pressed".
  assign w_inc_act = i_key_inc ^ KEY_ACTIVE_LOW;
  assign w_dec_act = i_key_dec ^ KEY_ACTIVE_LOW;

  // Two-flop synchroniser plus a history flop for each key channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inc_s1   <= 1'b0;
      r_inc_s2   <= 1'b0;
      r_inc_prev <= 1'b0;
      r_dec_s1   <= 1'b0;
      r_dec_s2   <= 1'b0;
      r_dec_prev <= 1'b0;
    end else begin
      r_inc_s1   <= w_inc_act;
      r_inc_s2   <= r_inc_s1;
      r_inc_prev <= r_inc_s2;
      r_dec_s1   <= w_dec_act;
      r_dec_s2   <= r_dec_s1;
      r_dec_prev <= r_dec_s2;
    end
  end

  // Rising edge of the synchronised level; release edges are ignored.
  assign o_inc_pulse = r_inc_s2 & ~r_inc_prev;
  assign o_dec_pulse = r_dec_s2 & ~r_dec_prev;

  // Tables are padded to the full address space with zeros so that
  // out-of-range addresses read 0 without a separate range compare.
  logic [15:0] w_rom11 [0:127];
  logic [7:0]  w_rom5  [0:31];

  for (genvar gi = 0; gi < 128; gi++) begin : g_rom11
    if (gi < 121) begin : g_used
      assign w_rom11[gi] = 16'(binom11(gi / 11) * binom11(gi % 11));
    end else begin : g_pad
      assign w_rom11[gi] = 16'd0;
    end
  end

  for (genvar gj = 0; gj < 32; gj++) begin : g_rom5
    if (gj < 25) begin : g_used
      assign w_rom5[gj] = 8'(gauss5(gj / 5) * gauss5(gj % 5));
    end else begin : g_pad
      assign w_rom5[gj] = 8'd0;
    end
  end

  // Registered 11x11 read; reset wins over a pending read, idle holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data11 <= 16'd0;
    end else if (i_rd_en11) begin
      o_data11 <= w_rom11[i_addr11];
    end
  end

  // Registered 5x5 read; reset wins over a pending read, idle holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data5 <= 8'd0;
    end else if (i_rd_en5) begin
      o_data5 <= w_rom5[i_addr5];
    end
  end

endmodule

// File: tb/tb_pulse_kernel_rom.sv
// tb_pulse_kernel_rom
// Directed bench for the key pulse generators and the two kernel ROMs.
// Expected results are queued as stimulus is driven and popped once the
// design has had its clock edge.

module tb_pulse_kernel_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyInc;
  logic        keyDec;
  logic        incPulse;
  logic        decPulse;
  logic        rdEn11;
  logic [6:0]  addr11;
  logic [15:0] data11;
  logic        rdEn5;
  logic [4:0]  addr5;
  logic [7:0]  data5;

  int checks = 0;
  int errors = 0;

  logic [1:0]  pulseQ [$];
  logic [15:0] rom11Q [$];
  logic [7:0]  rom5Q  [$];

  pulse_kernel_rom #(.KEY_ACTIVE_LOW(1'b1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_inc   (keyInc),
    .i_key_dec   (keyDec),
    .o_inc_pulse (incPulse),
    .o_dec_pulse (decPulse),
    .i_rd_en11   (rdEn11),
    .i_addr11    (addr11),
    .o_data11    (data11),
    .i_rd_en5    (rdEn5),
    .i_addr5     (addr5),
    .o_data5     (data5)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Binomial coefficient C(n,k), built multiplicatively.
  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    for (int j = 0; j < k; j++) c = c * (n - j) / (j + 1);
    return c;
  endfunction

  function automatic logic [15:0] model11(input int idx);
    if (idx > 120) return 16'd0;
    return 16'(binom(10, idx / 11) * binom(10, idx % 11));
  endfunction

  function automatic logic [7:0] model5(input int idx);
    if (idx > 24) return 8'd0;
    return 8'(binom(4, idx / 5) * binom(4, idx % 5));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic ki, input logic kd);
    rst    = r;
    keyInc = ki;
    keyDec = kd;
  endtask

  // Queue the pulse pair expected after the coming edge, then compare.
  task automatic stepPulse(input string tag, input logic expInc, input logic expDec);
    logic [1:0] e;
    pulseQ.push_back({expInc, expDec});
    tick();
    e = pulseQ.pop_front();
    checkOutput({tag, ".inc"}, {31'd0, incPulse}, {31'd0, e[1]});
    checkOutput({tag, ".dec"}, {31'd0, decPulse}, {31'd0, e[0]});
  endtask

  task automatic read11(input string tag, input int a, input logic [15:0] expected);
    logic [15:0] e;
    rdEn11 = 1'b1;
    addr11 = 7'(a);
    rom11Q.push_back(expected);
    tick();
    e = rom11Q.pop_front();
    checkOutput(tag, {16'd0, data11}, {16'd0, e});
  endtask

  task automatic read5(input string tag, input int a, input logic [7:0] expected);
    logic [7:0] e;
    rdEn5 = 1'b1;
    addr5 = 5'(a);
    rom5Q.push_back(expected);
    tick();
    e = rom5Q.pop_front();
    checkOutput(tag, {24'd0, data5}, {24'd0, e});
  endtask

  // Whole directed sequence.
  initial begin
    int sum11;
    int sum5;

    applyStimulus(1'b1, 1'b1, 1'b1);
    rdEn11 = 1'b1;
    addr11 = 7'd60;
    rdEn5  = 1'b1;
    addr5  = 5'd12;
    tick();
    tick();
    checkOutput("reset.inc", {31'd0, incPulse}, 32'd0);
    checkOutput("reset.dec", {31'd0, decPulse}, 32'd0);
    checkOutput("reset.data11", {16'd0, data11}, 32'd0);
    checkOutput("reset.data5", {24'd0, data5}, 32'd0);
    rdEn11 = 1'b0;
    rdEn5  = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1);
    stepPulse("idle0", 1'b0, 1'b0);
    stepPulse("idle1", 1'b0, 1'b0);

    // Held increment press: one pulse on the second edge, nothing else.
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepPulse("inc.k", 1'b0, 1'b0);
    stepPulse("inc.k1", 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) stepPulse("inc.hold", 1'b0, 1'b0);

    // Release produces no pulse.
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) stepPulse("inc.release", 1'b0, 1'b0);

    // Simultaneous presses pulse together.
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepPulse("both.k", 1'b0, 1'b0);
    stepPulse("both.k1", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) stepPulse("both.hold", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) stepPulse("both.release", 1'b0, 1'b0);

    // Decrement press, reset lands while its pulse is high, key stays held.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepPulse("dec.k", 1'b0, 1'b0);
    stepPulse("dec.k1", 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) stepPulse("dec.inreset", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepPulse("dec.post1", 1'b0, 1'b0);
    stepPulse("dec.post2", 1'b0, 1'b1);
    stepPulse("dec.post3", 1'b0, 1'b0);
    stepPulse("dec.post4", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepPulse("dec.release", 1'b0, 1'b0);

    // 11x11 directed reads including the corner, centre and out of range.
    read11("rom11.a0", 0, 16'd1);
    read11("rom11.a1", 1, 16'd10);
    read11("rom11.a60", 60, 16'd63504);
    read11("rom11.a120", 120, 16'd1);
    read11("rom11.a121", 121, 16'd0);
    read11("rom11.a127", 127, 16'd0);
    read11("rom11.a16", 16, 16'd2520);

    // 11x11 hold while disabled.
    read11("rom11.reload", 60, 16'd63504);
    rdEn11 = 1'b0;
    addr11 = 7'd0;
    tick();
    checkOutput("rom11.hold", {16'd0, data11}, 32'd63504);

    // 5x5 directed reads.
    read5("rom5.a12", 12, 8'd36);
    read5("rom5.a7", 7, 8'd24);
    read5("rom5.a0", 0, 8'd1);
    read5("rom5.a30", 30, 8'd0);
    read5("rom5.a25", 25, 8'd0);
    read5("rom5.reload", 12, 8'd36);

    // 5x5 hold while disabled with a changing address.
    rdEn5 = 1'b0;
    addr5 = 5'd7;
    tick();
    checkOutput("rom5.hold1", {24'd0, data5}, 32'd36);
    addr5 = 5'd0;
    tick();
    checkOutput("rom5.hold2", {24'd0, data5}, 32'd36);

    // Full sweeps: per-entry model and kernel normalisation.
    sum11 = 0;
    for (int i = 0; i < 121; i++) begin
      read11("rom11.sweep", i, model11(i));
      sum11 += int'(data11);
    end
    checkOutput("rom11.sum", sum11, 32'd1048576);

    sum5 = 0;
    for (int i = 0; i < 25; i++) begin
      read5("rom5.sweep", i, model5(i));
      sum5 += int'(data5);
    end
    checkOutput("rom5.sum", sum5, 32'd256);

    // Reset takes priority over an active read.
    rdEn11 = 1'b1;
    addr11 = 7'd60;
    rdEn5  = 1'b1;
    addr5  = 5'd12;
    rst    = 1'b1;
    tick();
    checkOutput("prio.data11", {16'd0, data11}, 32'd0);
    checkOutput("prio.data5", {24'd0, data5}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("prio.after11", {16'd0, data11}, 32'd63504);
    checkOutput("prio.after5", {24'd0, data5}, 32'd36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
